sonic_rx_dma_sched: RTL and testbench
=====================================

Name: sonic_rx_dma_sched

Overview:
- Read-side scheduler for the 66-bit RX circular buffer. Runs in the DMA read clock domain.
- Compares the clock-crossed RX write pointer with its own read pointer and decides when enough 128-bit lines are present.
- Issues fixed-size, or timeout-flushed partial, read bursts as rd_address/rdreq, tags returning data with valid/last, and raises a host interrupt per completed burst.
- Sits between the RX buffer control wrapper and the PCIe DMA engine.

Parameters:
- QWORD_DEPTH, 15872, ring size in 64-bit qwords; must be even. Ring holds QWORD_DEPTH/2 = 7936 lines.
- BURST_LINES, 16, 128-bit lines per full burst; range 1..255.
- FLUSH_TIMEOUT, 1024, idle cycles with 0 < avail < BURST_LINES before a partial burst is issued.
- READ_LATENCY, 2, cycles from rdreq to data_out valid at the buffer RAM.

Ports:
- rd_clock, in, 1: DMA read clock; the only clock.
- reset_n, in, 1: asynchronous active-low reset.
- enable, in, 1: scheduler enable (SFP enabled and transceiver ready).
- rx_ring_wptr, in, 14: clock-crossed write pointer, in qwords, modulo QWORD_DEPTH.
- dma_ready, in, 1: DMA engine accepts one line this cycle.
- rdreq, out, 1: buffer read strobe.
- rd_address, out, 13: buffer line index.
- rx_ring_rptr, out, 14: committed read pointer in qwords; always even.
- data_valid, out, 1: data_out from the buffer is valid this cycle.
- data_last, out, 1: valid line is the final line of its burst.
- burst_len, out, 8: length of the current/last burst, in lines.
- irq, out, 1: sticky burst-complete interrupt.
- irq_ack, in, 1: clears irq.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; flush timer 0; latency pipe cleared. Reset mid-burst abandons the burst with no completion and no irq.
- Availability, combinational:
  - diff = wptr - rptr, plus QWORD_DEPTH if negative (15-bit intermediate).
  - avail_lines = diff >> 1. An odd trailing qword waits for its partner.
- rd_address = rptr[13:1] at all times.
- Line advance: rptr += 2; if the result equals QWORD_DEPTH it becomes 0.
- IDLE:
  - If enable && avail_lines >= BURST_LINES: latch burst_len = BURST_LINES, go to STREAM.
  - Else if enable && avail_lines > 0: increment the flush timer. When it reaches FLUSH_TIMEOUT-1, latch burst_len = avail_lines and go to STREAM.
  - The timer clears on entering STREAM, whenever avail_lines == 0, and whenever enable == 0.
- STREAM:
  - rdreq = dma_ready. Each cycle with rdreq=1: advance rptr and increment the line counter.
  - dma_ready low stalls with no rdreq and no advance; unlimited stall is allowed.
  - When the counter reaches burst_len on an issuing cycle, go to DRAIN.
  - enable falling mid-burst is ignored; the burst completes.
- DRAIN:
  - Wait until the latency pipe is empty, i.e. READ_LATENCY cycles after the last rdreq.
  - Then set irq and return to IDLE. This is 1 cycle minimum if READ_LATENCY is 0.
- Latency pipe: a READ_LATENCY-deep shift register of {rdreq, last_flag}.
  - Its output drives data_valid and data_last.
  - last_flag = 1 on the rdreq that completes burst_len.
- burst_len never exceeds the avail_lines latched at burst start, so underflow is impossible: rdreq is never issued past wptr.
- Overflow is the write side's responsibility; the committed rx_ring_rptr is exported for the writer's full calculation.
- Wrap-around: a burst may cross the ring end. rd_address goes 7935 -> 0 with no gap.
- irq: set on DRAIN exit, cleared by irq_ack. If set and ack occur in the same cycle, set wins.
- Pointer width: rx_ring_wptr >= QWORD_DEPTH is out of contract; behaviour is undefined.

Test Plan:
- Reset, then wptr=32 with enable=1 and dma_ready=1 -> 16 rdreq cycles, rd_address 0..15, rx_ring_rptr=32.
  - data_valid pulses 2 cycles delayed; data_last on the 16th; irq=1; burst_len=16.
- wptr=6 held, enable=1 -> no rdreq for 1023 cycles, then a 3-line partial burst (burst_len=3, addresses 0..2), rptr=6, irq.
  - wptr=7 -> same burst; the odd qword stays and rptr ends at 6.
- rptr preset to 15860 via prior traffic, wptr=12 (avail = (12+15872-15860)/2 = 12, then fill to 16) -> addresses 7930..7935, 0..9 contiguous; rptr ends at 20.
- dma_ready toggled 1,0,0,1,... during a full burst -> rdreq only on ready cycles; exactly 16 advances; data_last on the 16th valid.
- irq_ack asserted the same cycle DRAIN sets irq -> irq stays 1; next irq_ack alone -> 0.
- reset_n low at line 7 of a burst -> outputs 0 immediately (asynchronously); after release, IDLE with rptr=0, no irq, no data_valid.

Source files
------------

// File: rtl/sonic_rx_dma_sched.sv
// rtl/sonic_rx_dma_sched.sv - RX ring read-side DMA burst scheduler
//
// Watches the clock-crossed write pointer of the 66-bit RX ring and issues
// 128-bit line reads to the buffer RAM in bursts. A burst is either a full
// BURST_LINES burst or a timeout-flushed partial burst. Returning data is
// tagged with valid/last, and a sticky irq is raised per completed burst.
//
// Ports:
//   rd_clock      DMA read clock (only clock)
//   reset_n       asynchronous active-low reset
//   enable        scheduler enable (SFP enabled, transceiver ready)
//   rx_ring_wptr  write pointer in qwords, modulo QWORD_DEPTH
//   dma_ready     DMA engine accepts one line this cycle
//   rdreq         buffer read strobe
//   rd_address    buffer line index (rptr / 2)
//   rx_ring_rptr  committed read pointer in qwords (always even)
//   data_valid    buffer data_out valid this cycle
//   data_last     valid line is the final line of its burst
//   burst_len     length of current/last burst in lines
//   irq           sticky burst-complete interrupt
//   irq_ack       clears irq (a same-cycle set wins)
module sonic_rx_dma_sched #(
   parameter int QWORD_DEPTH   = 15872,
   parameter int BURST_LINES   = 16,
   parameter int FLUSH_TIMEOUT = 1024,
   parameter int READ_LATENCY  = 2
) (
   input  logic        rd_clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [13:0] rx_ring_wptr,
   input  logic        dma_ready,
   output logic        rdreq,
   output logic [12:0] rd_address,
   output logic [13:0] rx_ring_rptr,
   output logic        data_valid,
   output logic        data_last,
   output logic [7:0]  burst_len,
   output logic        irq,
   input  logic        irq_ack
);

   localparam int PW = (READ_LATENCY > 0) ? READ_LATENCY : 1;
   localparam int TW = $clog2(FLUSH_TIMEOUT + 1) + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [13:0]     rptr;
   logic [TW-1:0]   timer, timer_nxt;
   logic [7:0]      line_cnt;
   logic [7:0]      len_r;
   logic            irq_r;
   logic [PW-1:0]   pipe_v, pipe_l;

   logic [14:0]     diff_raw, diff;
   logic [13:0]     avail_lines;
   logic            start;
   logic [7:0]      start_len;
   logic            last_c;
   logic            irq_set;
   logic            pipe_empty;
   logic [13:0]     rptr_nxt;

   // Ring occupancy in qwords. The 15-bit subtraction borrows into bit 14
   // exactly when wptr < rptr, which is when the ring size must be added back.
   always_comb begin
      diff_raw    = {1'b0, rx_ring_wptr} - {1'b0, rptr};
      diff        = diff_raw[14] ? (diff_raw + 15'(QWORD_DEPTH)) : diff_raw;
      avail_lines = 14'(diff >> 1);
   end

   assign rptr_nxt   = (rptr == 14'(QWORD_DEPTH - 2)) ? 14'd0 : (rptr + 14'd2);
   assign pipe_empty = (READ_LATENCY == 0) ? 1'b1 : (pipe_v == '0);

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      start     = 1'b0;
      start_len = 8'd0;
      rdreq     = 1'b0;
      last_c    = 1'b0;
      irq_set   = 1'b0;
      case (state)
         IDLE: begin
            if (enable && (avail_lines >= 14'(BURST_LINES))) begin
               start     = 1'b1;
               start_len = 8'(BURST_LINES);
               timer_nxt = '0;
               state_nxt = STREAM;
            end else if (enable && (avail_lines != 14'd0)) begin
               // Partial lines below BURST_LINES fit in 8 bits.
               if ((int'(timer) + 1) >= (FLUSH_TIMEOUT - 1)) begin
                  start     = 1'b1;
                  start_len = avail_lines[7:0];
                  timer_nxt = '0;
                  state_nxt = STREAM;
               end else begin
                  timer_nxt = timer + TW'(1);
               end
            end else begin
               timer_nxt = '0;
            end
         end
         STREAM: begin
            rdreq = dma_ready;
            if (dma_ready && ((line_cnt + 8'd1) == len_r)) begin
               last_c    = 1'b1;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Hold off the interrupt until the last line has left the pipe.
            if (pipe_empty) begin
               irq_set   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge rd_clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         rptr     <= '0;
         timer    <= '0;
         line_cnt <= '0;
         len_r    <= '0;
         irq_r    <= 1'b0;
         pipe_v   <= '0;
         pipe_l   <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         if (start) begin
            len_r    <= start_len;
            line_cnt <= '0;
         end else if (rdreq) begin
            line_cnt <= line_cnt + 8'd1;
         end
         if (rdreq) begin
            rptr <= rptr_nxt;
         end
         if (irq_set) begin
            irq_r <= 1'b1;
         end else if (irq_ack) begin
            irq_r <= 1'b0;
         end
         pipe_v[0] <= rdreq;
         pipe_l[0] <= last_c;
         for (int i = 1; i < PW; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_l[i] <= pipe_l[i-1];
         end
      end
   end

   assign rd_address   = rptr[13:1];
   assign rx_ring_rptr = rptr;
   assign burst_len    = len_r;
   assign irq          = irq_r;
   assign data_valid   = (READ_LATENCY == 0) ? rdreq  : pipe_v[PW-1];
   assign data_last    = (READ_LATENCY == 0) ? last_c : pipe_l[PW-1];

endmodule

// File: tb/tb_sonic_rx_dma_sched.sv
// tb/tb_sonic_rx_dma_sched.sv - self-checking bench for sonic_rx_dma_sched
module tb_sonic_rx_dma_sched;

   localparam int D     = 15872;
   localparam int LINES = D / 2;
   localparam int BL    = 16;

   logic        rd_clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [13:0] rx_ring_wptr = '0;
   logic        dma_ready = 1'b0;
   logic        irq_ack = 1'b0;
   logic        rdreq;
   logic [12:0] rd_address;
   logic [13:0] rx_ring_rptr;
   logic        data_valid;
   logic        data_last;
   logic [7:0]  burst_len;
   logic        irq;

   sonic_rx_dma_sched dut (
      .rd_clock     (rd_clock),
      .reset_n      (reset_n),
      .enable       (enable),
      .rx_ring_wptr (rx_ring_wptr),
      .dma_ready    (dma_ready),
      .rdreq        (rdreq),
      .rd_address   (rd_address),
      .rx_ring_rptr (rx_ring_rptr),
      .data_valid   (data_valid),
      .data_last    (data_last),
      .burst_len    (burst_len),
      .irq          (irq),
      .irq_ack      (irq_ack)
   );

   always #5 rd_clock = ~rd_clock;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int wptr;
      bit toggle;
      bit ack_hold;
      bit prefill;
      int exp_len;
      int exp_first;
      int exp_rptr;
      int exp_wait;
   } row_t;

   row_t rows[6];

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic prefill_to(input int target);
      int cnt;
      @(negedge rd_clock);
      rx_ring_wptr = 14'(target);
      dma_ready = 1'b1;
      irq_ack = 1'b0;
      cnt = 0;
      while (cnt < 20000) begin
         @(negedge rd_clock);
         irq_ack = 1'b0;
         #1;
         if (irq) begin
            if (rx_ring_rptr == 14'(target)) break;
            irq_ack = 1'b1;
         end
         cnt++;
      end
      check("prefill_rptr", rx_ring_rptr, target);
      irq_ack = 1'b1;
      @(negedge rd_clock);
      irq_ack = 1'b0;
   endtask

   initial begin
      int wait_c, n, nvalid, cyc, pi, first_c, last_c;
      bit got_irq, h1, h2;
      int model_w, model_r, occ, inc, avail, bcount, pend_last, nlast;
      bit prev_irq;

      // first/len/rptr follow from the ring arithmetic of each preceding row
      rows[0] = '{wptr: 32, toggle: 0, ack_hold: 0, prefill: 0, exp_len: 16, exp_first: 0,    exp_rptr: 32, exp_wait: 1};
      rows[1] = '{wptr: 38, toggle: 0, ack_hold: 0, prefill: 0, exp_len: 3,  exp_first: 16,   exp_rptr: 38, exp_wait: 1023};
      rows[2] = '{wptr: 45, toggle: 0, ack_hold: 0, prefill: 0, exp_len: 3,  exp_first: 19,   exp_rptr: 44, exp_wait: 1023};
      rows[3] = '{wptr: 76, toggle: 1, ack_hold: 0, prefill: 0, exp_len: 16, exp_first: 22,   exp_rptr: 76, exp_wait: 1};
      rows[4] = '{wptr: 20, toggle: 0, ack_hold: 0, prefill: 1, exp_len: 16, exp_first: 7930, exp_rptr: 20, exp_wait: 1};
      rows[5] = '{wptr: 52, toggle: 0, ack_hold: 1, prefill: 0, exp_len: 16, exp_first: 10,   exp_rptr: 52, exp_wait: 1};

      // reset state
      repeat (3) @(negedge rd_clock);
      #1;
      check("reset_rdreq", rdreq, 0);
      check("reset_rd_address", rd_address, 0);
      check("reset_rptr", rx_ring_rptr, 0);
      check("reset_valid", data_valid, 0);
      check("reset_last", data_last, 0);
      check("reset_burst_len", burst_len, 0);
      check("reset_irq", irq, 0);
      @(negedge rd_clock);
      reset_n = 1'b1;
      enable = 1'b1;
      dma_ready = 1'b1;
      repeat (2) @(negedge rd_clock);

      for (int i = 0; i < 6; i++) begin
         if (rows[i].prefill) prefill_to(15860);
         @(negedge rd_clock);
         rx_ring_wptr = 14'(rows[i].wptr);
         dma_ready = 1'b1;
         irq_ack = rows[i].ack_hold;
         #1;
         wait_c = 0;
         while (!rdreq && wait_c < 3000) begin
            wait_c++;
            @(negedge rd_clock);
            #1;
         end
         check("start_wait", wait_c, rows[i].exp_wait);

         n = 0; nvalid = 0; cyc = 0; pi = 0; first_c = -1; last_c = -1;
         got_irq = 0; h1 = 0; h2 = 0;
         while (!got_irq && cyc < 400) begin
            check("burst_valid", data_valid, h2);
            if (data_valid) begin
               nvalid++;
               check("burst_last", data_last, (nvalid == rows[i].exp_len));
            end else begin
               check("burst_last_idle", data_last, 0);
            end
            if (rdreq) begin
               check("burst_addr", rd_address, (rows[i].exp_first + n) % LINES);
               if (first_c < 0) first_c = cyc;
               last_c = cyc;
               n++;
            end
            h2 = h1;
            h1 = rdreq;
            if (irq) begin
               got_irq = 1;
            end else begin
               @(negedge rd_clock);
               dma_ready = rows[i].toggle ? ((pi % 3) == 2) : 1'b1;
               pi++;
               #1;
               cyc++;
            end
         end
         check("burst_irq", got_irq, 1);
         check("burst_rdreq_count", n, rows[i].exp_len);
         check("burst_valid_count", nvalid, rows[i].exp_len);
         check("burst_len", burst_len, rows[i].exp_len);
         check("burst_rptr", rx_ring_rptr, rows[i].exp_rptr);
         check("burst_span", last_c - first_c,
               rows[i].toggle ? 3 * (rows[i].exp_len - 1) : rows[i].exp_len - 1);
         if (!rows[i].ack_hold) irq_ack = 1'b1;
         @(negedge rd_clock);
         irq_ack = 1'b0;
         dma_ready = 1'b1;
         #1;
         check("irq_cleared", irq, 0);
      end

      // randomized traffic against a ring-occupancy model
      model_w = 52; model_r = 52; h1 = 0; h2 = 0;
      bcount = 0; pend_last = 0; nlast = 0; prev_irq = 0;
      for (int c = 0; c < 9000; c++) begin
         @(negedge rd_clock);
         dma_ready = ($urandom % 4) != 0;
         irq_ack = ($urandom % 8) == 0;
         if (c < 6000) begin
            enable = ($urandom % 64) != 0;
            if (($urandom % 3) == 0) begin
               inc = $urandom_range(1, 6);
               occ = (model_w - model_r + D) % D;
               if (occ + inc < 400) model_w = (model_w + inc) % D;
            end
         end else begin
            enable = 1'b1;
            dma_ready = 1'b1;
         end
         rx_ring_wptr = 14'(model_w);
         #1;
         check("rand_rptr", rx_ring_rptr, model_r);
         check("rand_rd_address", rd_address, model_r / 2);
         if (rdreq) begin
            avail = ((model_w - model_r + D) % D) / 2;
            check("rand_no_underflow", avail > 0, 1);
            model_r = (model_r + 2) % D;
         end
         check("rand_valid", data_valid, h2);
         if (data_valid) begin
            bcount++;
            if (data_last) begin
               check("rand_burst_size", (bcount >= 1) && (bcount <= BL), 1);
               bcount = 0;
               nlast++;
               pend_last++;
            end
         end else begin
            check("rand_last_idle", data_last, 0);
         end
         if (irq && !prev_irq) begin
            check("rand_irq_after_last", pend_last > 0, 1);
            pend_last = 0;
         end
         prev_irq = irq;
         h2 = h1;
         h1 = rdreq;
      end
      check("rand_drained", model_r, model_w & ~1);
      check("rand_bursts_seen", nlast > 0, 1);

      // reset in the middle of a burst
      @(negedge rd_clock);
      irq_ack = 1'b1;
      enable = 1'b1;
      dma_ready = 1'b1;
      @(negedge rd_clock);
      irq_ack = 1'b0;
      rx_ring_wptr = 14'((model_r + 32) % D);
      n = 0; cyc = 0;
      #1;
      while (n < 7 && cyc < 3000) begin
         if (rdreq) n++;
         if (n < 7) begin
            @(negedge rd_clock);
            #1;
            cyc++;
         end
      end
      check("reset_reached_line7", n, 7);
      #1;
      reset_n = 1'b0;
      #1;
      check("midreset_rdreq", rdreq, 0);
      check("midreset_rd_address", rd_address, 0);
      check("midreset_rptr", rx_ring_rptr, 0);
      check("midreset_valid", data_valid, 0);
      check("midreset_last", data_last, 0);
      check("midreset_burst_len", burst_len, 0);
      check("midreset_irq", irq, 0);
      rx_ring_wptr = '0;
      repeat (2) @(negedge rd_clock);
      reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge rd_clock);
         #1;
         check("post_reset_rdreq", rdreq, 0);
         check("post_reset_valid", data_valid, 0);
         check("post_reset_irq", irq, 0);
         check("post_reset_rptr", rx_ring_rptr, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
